// File: rtl/layer_pass_ctrl_pkg.sv
// layer_pass_ctrl_pkg: shared FSM state type, counter width and default geometry
package layer_pass_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, NEXT, DONE} state_t;
    localparam int PIX_W = 16;
    localparam int DEF_WIDTH = 56;
    localparam int DEF_HEIGHT = 56;
    localparam int DEF_NUM_GROUPS = 8;
endpackage

// File: rtl/layer_pass_ctrl_pix_frame_counter.sv
// pix_frame_counter: per-pass pixel counter with clear, enable and terminal count
module pix_frame_counter
    import layer_pass_ctrl_pkg::*;
#(
    parameter int NUM_PIX = DEF_WIDTH * DEF_HEIGHT
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr,
    input  logic             en,
    output logic             tc,
    output logic [PIX_W-1:0] cnt
);
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    assign tc = (cnt == PIX_W'(NUM_PIX - 1));
endmodule

// File: rtl/layer_pass_ctrl.sv
// layer_pass_ctrl: sequences weight load and datapath passes over all output-channel groups
module layer_pass_ctrl
    import layer_pass_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int NUM_GROUPS = DEF_NUM_GROUPS,
    localparam int GW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    output logic             wgt_load_req,
    input  logic             wgt_load_ack,
    output logic             pass_start,
    input  logic             data_valid_in,
    output logic [GW-1:0]    grp_idx,
    output logic [PIX_W-1:0] pix_cnt,
    output logic             pass_done,
    output logic             layer_done,
    output logic             busy,
    output logic             err_overrun
);
    localparam int NUM_PIX = WIDTH * HEIGHT;
    state_t state, nxt;
    logic tc, last, accept;
    assign last = (grp_idx == GW'(NUM_GROUPS - 1));
    assign accept = (state == IDLE) && start;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) state <= IDLE;
        else state <= nxt;
    // abort overrides every other transition out of a non-idle state
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? LOAD : IDLE;
            LOAD:    nxt = wgt_load_ack ? START : LOAD;
            START:   nxt = RUN;
            RUN:     nxt = (data_valid_in && tc) ? NEXT : RUN;
            NEXT:    nxt = last ? DONE : LOAD;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (abort && state != IDLE) nxt = IDLE;
    end
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            grp_idx <= '0;
            err_overrun <= 1'b0;
        end else begin
            if (accept) grp_idx <= '0;
            else if (state == NEXT && !last && !abort) grp_idx <= grp_idx + 1'b1;
            err_overrun <= (data_valid_in && state != RUN) || (err_overrun && !accept);
        end
    pix_frame_counter #(.NUM_PIX(NUM_PIX)) u_cnt (
        .clk(clk),
        .resetn(resetn),
        .clr(state == START),
        .en(state == RUN && data_valid_in),
        .tc(tc),
        .cnt(pix_cnt)
    );
    assign wgt_load_req = (state == LOAD);
    assign pass_start = (state == START);
    assign pass_done = (state == NEXT);
    assign layer_done = (state == DONE);
    assign busy = (state != IDLE);
endmodule

// File: tb/tb_layer_pass_ctrl.sv
// tb_layer_pass_ctrl: directed scenarios with a queue-based event scoreboard
module tb_layer_pass_ctrl;
    localparam int NG = 3;
    logic clk = 0, resetn = 0, start = 0, abort = 0, ack = 0, valid = 0;
    logic req, ps, pd, ld, busy, err;
    logic [1:0] grp;
    logic [15:0] pix;
    typedef struct {int kind; int grp; int pix;} ev_t;
    ev_t q[$];
    int checks = 0, errors = 0;

    layer_pass_ctrl #(.WIDTH(4), .HEIGHT(2), .NUM_GROUPS(NG)) dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .wgt_load_req(req), .wgt_load_ack(ack), .pass_start(ps),
        .data_valid_in(valid), .grp_idx(grp), .pix_cnt(pix),
        .pass_done(pd), .layer_done(ld), .busy(busy), .err_overrun(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input int g, input int p);
        ev_t e;
        e.kind = k; e.grp = g; e.pix = p;
        q.push_back(e);
    endtask

    // kind 0 = pass_start, 1 = pass_done, 2 = layer_done
    always @(negedge clk) begin
        if (resetn && (ps || pd || ld)) begin
            ev_t e;
            int k;
            k = ld ? 2 : (pd ? 1 : 0);
            if (q.size() == 0) chk("unexpected_event", k, 32'hffff);
            else begin
                e = q.pop_front();
                chk("ev_kind", k, e.kind);
                chk("ev_grp", {30'd0, grp}, e.grp);
                if (e.pix >= 0) chk("ev_pix", {16'd0, pix}, e.pix);
            end
        end
    end

    task automatic run_pass(input int g, input bit gap, input int dly, input bit ovr,
                            input bit abt, input bit rst5, output bit stop);
        int hi = 0;
        stop = 0;
        chk("req_in_load", req, 1);
        if (ovr) begin
            valid = 1; tick; valid = 0;
            chk("ovr_err_set", err, 1);
            chk("ovr_pix_hold", pix, 8);
        end
        for (int i = 0; i < dly; i++) begin
            hi += int'(req);
            tick;
        end
        if (dly > 1) chk("req_held", hi, dly);
        push(0, g, -1);
        ack = 1; tick; ack = 0;
        chk("pass_start_lat", ps, 1);
        if (!abt) push(1, g, 8);
        if (!abt && g == NG - 1) push(2, g, 8);
        tick;
        chk("pix_clear", pix, 0);
        for (int i = 0; i < 8; i++) begin
            if (rst5 && i == 5) begin
                chk("pix_at5", pix, 5);
                #2 resetn = 0;
                #1;
                chk("rst_outs", {req, ps, pd, ld, busy, err}, 0);
                chk("rst_grp", grp, 0);
                chk("rst_pix", pix, 0);
                q.delete();
                tick; tick;
                resetn = 1;
                stop = 1;
                return;
            end
            valid = 1; abort = abt && i == 7; tick; valid = 0; abort = 0;
            if (i < 7) chk("no_early_done", pd, 0);
            if (gap && i < 7) repeat ($urandom_range(0, 3)) tick;
        end
        if (abt) begin
            chk("abort_idle", busy, 0);
            chk("abort_no_done", {pd, ld}, 0);
            tick; tick;
            chk("abort_still_quiet", {busy, pd, ld}, 0);
            stop = 1;
            return;
        end
        chk("pass_done_lat", pd, 1);
        chk("pix_in_next", pix, 8);
        tick;
        if (g == NG - 1) begin
            chk("layer_done_lat", ld, 1);
            tick;
            chk("busy_low", busy, 0);
        end else begin
            chk("next_req", req, 1);
            chk("grp_inc", grp, g + 1);
        end
    endtask

    task automatic run_layer(input bit gap, input int dly, input int ovr_g,
                             input bit abt, input bit rst5);
        bit stop;
        start = 1; tick; start = 0;
        chk("start_req_lat", req, 1);
        chk("start_grp0", grp, 0);
        chk("start_err_clr", err, 0);
        chk("start_busy", busy, 1);
        for (int g = 0; g < NG; g++) begin
            run_pass(g, gap, dly, g == ovr_g, abt && g == NG - 1, rst5 && g == 1, stop);
            if (stop) break;
        end
        tick;
    endtask

    initial begin
        #3;
        chk("por_outs", {req, ps, pd, ld, busy, err}, 0);
        chk("por_grp", grp, 0);
        chk("por_pix", pix, 0);
        tick;
        resetn = 1;
        tick;
        run_layer(0, 1, -1, 0, 0);
        run_layer(1, 1, -1, 0, 0);
        run_layer(0, 10, -1, 0, 0);
        run_layer(0, 1, 1, 0, 0);
        chk("err_sticky", err, 1);
        run_layer(0, 1, -1, 0, 0);
        run_layer(0, 1, -1, 1, 0);
        run_layer(0, 1, -1, 0, 0);
        run_layer(0, 1, -1, 0, 1);
        run_layer(0, 1, -1, 0, 0);
        repeat (3) tick;
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
